// File: rtl/mmio_io_ctrl_pkg.sv
// rtl/mmio_io_ctrl_pkg.sv - register offsets and status codes for the MMIO I/O controller
package mmio_pkg;
  localparam logic [2:0] OFF_EVENT   = 3'd0;
  localparam logic [2:0] OFF_LED     = 3'd1;
  localparam logic [2:0] OFF_SW      = 3'd2;
  localparam logic [2:0] OFF_STATUS  = 3'd3;
  localparam logic [2:0] OFF_LEVEL   = 3'd4;
  localparam logic [2:0] OFF_PENDING = 3'd5;

  localparam logic [1:0] STATUS_WIN  = 2'b01;
  localparam logic [1:0] STATUS_LOSS = 2'b10;
endpackage

// File: rtl/mmio_io_ctrl_if.sv
// rtl/mmio_io_ctrl_if.sv - processor data-port bus into the MMIO I/O controller
interface mmio_io_ctrl_if;
  logic [31:0] addr;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        hit;

  modport master (output addr, output wr_en, output rd_en, output wr_data,
                  input rd_data, input hit);
  modport slave  (input addr, input wr_en, input rd_en, input wr_data,
                  output rd_data, output hit);
endinterface

// File: rtl/mmio_io_ctrl_btn_debounce.sv
// rtl/mmio_io_ctrl_btn_debounce.sv - per-button 2-flop synchroniser, debounce counter and rise pulse
module btn_debounce #(
  parameter int DB_CYCLES = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic rise
);
  // DB_CYCLES=1 would give a zero-width counter; keep one bit so LAST=0 accepts at once.
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;
  logic          accept;

  // The toggle edge and the rise pulse coincide so pending sets together with the level.
  assign accept = (sync_2 != level) && (cnt == LAST);
  assign rise   = accept && !level;

  // Synchronise, then count consecutive cycles that disagree with the accepted level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_1 <= btn_in;
      sync_2 <= sync_1;
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/mmio_io_ctrl.sv
// rtl/mmio_io_ctrl.sv - MMIO decode, LED/status registers, button event capture and irq
module mmio_io_ctrl
  import mmio_pkg::*;
#(
  parameter int BASE_ADDR = 4096,
  parameter int NUM_BTN   = 4,
  parameter int SW_W      = 16,
  parameter int LED_W     = 16,
  parameter int STAT_W    = 2,
  parameter int DB_CYCLES = 250000
) (
  input  logic               clock,
  input  logic               reset,
  mmio_io_ctrl_if.slave      bus,
  input  logic [NUM_BTN-1:0] btn_in,
  input  logic [SW_W-1:0]    sw_in,
  output logic [LED_W-1:0]   led,
  output logic [STAT_W-1:0]  status,
  output logic               irq
);
  localparam int CODE_W = $clog2(NUM_BTN + 1);

  logic [31:0]        off_full;
  logic [2:0]         off;
  logic               hit_i;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] lowest;
  logic [NUM_BTN-1:0] clr;
  logic [CODE_W-1:0]  code;
  logic [SW_W-1:0]    sw_s1;
  logic [SW_W-1:0]    sw_s2;
  logic [31:0]        rd_mux;
  logic               unused_wr;

  // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
  assign off_full  = bus.addr - 32'(BASE_ADDR);
  assign hit_i     = off_full < 32'd6;
  assign off       = off_full[2:0];
  assign bus.hit   = hit_i;
  assign unused_wr = ^bus.wr_data;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clock  (clock),
      .reset  (reset),
      .btn_in (btn_in[g]),
      .level  (level[g]),
      .rise   (rise[g])
    );
  end

  // Lowest-index pending button: its 1-based code and the one-hot bit an EVENT read clears.
  always_comb begin
    code   = '0;
    lowest = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pending[i]) begin
        code      = CODE_W'(i + 1);
        lowest    = '0;
        lowest[i] = 1'b1;
      end
    end
  end

  assign clr = (bus.rd_en && hit_i && off == OFF_EVENT) ? lowest : '0;

  // Read mux; unused upper bits and misses return zero.
  always_comb begin
    rd_mux = '0;
    if (hit_i) begin
      case (off)
        OFF_EVENT:   rd_mux[CODE_W-1:0]  = code;
        OFF_LED:     rd_mux[LED_W-1:0]   = led;
        OFF_SW:      rd_mux[SW_W-1:0]    = sw_s2;
        OFF_STATUS:  rd_mux[STAT_W-1:0]  = status;
        OFF_LEVEL:   rd_mux[NUM_BTN-1:0] = level;
        OFF_PENDING: rd_mux[NUM_BTN-1:0] = pending;
        default:     rd_mux = '0;
      endcase
    end
  end

  assign bus.rd_data = rd_mux;

  // Register stores, switch sync, sticky pending (a new rise beats the clear) and irq.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      led     <= '0;
      status  <= '0;
      pending <= '0;
      irq     <= 1'b0;
      sw_s1   <= '0;
      sw_s2   <= '0;
    end else begin
      if (bus.wr_en && hit_i && off == OFF_LED)    led    <= bus.wr_data[LED_W-1:0];
      if (bus.wr_en && hit_i && off == OFF_STATUS) status <= bus.wr_data[STAT_W-1:0];
      pending <= (pending & ~clr) | rise;
      irq     <= |pending;
      sw_s1   <= sw_in;
      sw_s2   <= sw_s1;
    end
  end
endmodule

// File: tb/tb_mmio_io_ctrl.sv
// tb/tb_mmio_io_ctrl.sv - directed self-checking bench for mmio_io_ctrl
module tb_mmio_io_ctrl;
  import mmio_pkg::*;

  localparam int BASE = 4096;

  logic        clock;
  logic        reset;
  logic [3:0]  btn_in;
  logic [15:0] sw_in;
  logic [15:0] led;
  logic [1:0]  status;
  logic        irq;
  int          total;
  int          bad;

  mmio_io_ctrl_if bus ();

  mmio_io_ctrl #(
    .BASE_ADDR(BASE), .NUM_BTN(4), .SW_W(16), .LED_W(16), .STAT_W(2), .DB_CYCLES(4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .btn_in(btn_in),
    .sw_in (sw_in),
    .led   (led),
    .status(status),
    .irq   (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic peek(input int offset);
    bus.addr = 32'(BASE + offset);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; btn_in = '0; sw_in = '0;
    bus.addr = '0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wr_data = '0;
    tick(3);
    reset = 1'b1;
    tick(2);
    total++; if ({led, status, irq} !== 19'd0) begin bad++; $display("FAIL reset_outs got=%h exp=0", {led, status, irq}); end
    for (int o = 0; o < 6; o++) begin
      peek(o);
      total++; if (bus.rd_data !== 32'd0) begin bad++; $display("FAIL reset_read off=%0d got=%h exp=0", o, bus.rd_data); end
      total++; if (bus.hit !== 1'b1) begin bad++; $display("FAIL hit_in off=%0d got=%b exp=1", o, bus.hit); end
    end
    bus.addr = 32'd4095; #1;
    total++; if (bus.hit !== 1'b0 || bus.rd_data !== 32'd0) begin bad++; $display("FAIL hit_4095 got=%b/%h exp=0/0", bus.hit, bus.rd_data); end
    bus.addr = 32'd4102; #1;
    total++; if (bus.hit !== 1'b0) begin bad++; $display("FAIL hit_4102 got=%b exp=0", bus.hit); end
  endtask

  task automatic test_regs;
    bus.addr = 32'd4097; bus.wr_data = 32'hFFFF_ABCD; bus.wr_en = 1'b1;
    tick(1);
    bus.addr = 32'd4099; bus.wr_data = 32'd2;
    tick(1);
    bus.wr_en = 1'b0;
    total++; if (led !== 16'hABCD) begin bad++; $display("FAIL led got=%h exp=abcd", led); end
    total++; if (status !== STATUS_LOSS) begin bad++; $display("FAIL status got=%b exp=10", status); end
    peek(1);
    total++; if (bus.rd_data !== 32'h0000_ABCD) begin bad++; $display("FAIL led_read got=%h exp=0000abcd", bus.rd_data); end
    peek(3);
    total++; if (bus.rd_data !== 32'd2) begin bad++; $display("FAIL status_read got=%h exp=2", bus.rd_data); end
  endtask

  task automatic test_sw;
    sw_in = 16'h1234;
    tick(1);
    peek(2);
    total++; if (bus.rd_data !== 32'd0) begin bad++; $display("FAIL sw_lat1 got=%h exp=0", bus.rd_data); end
    tick(1);
    peek(2);
    total++; if (bus.rd_data !== 32'h1234) begin bad++; $display("FAIL sw_lat2 got=%h exp=1234", bus.rd_data); end
    bus.wr_data = 32'h5555; bus.wr_en = 1'b1;
    tick(1);
    bus.wr_en = 1'b0;
    peek(2);
    total++; if (bus.rd_data !== 32'h1234) begin bad++; $display("FAIL sw_ro got=%h exp=1234", bus.rd_data); end
    total++; if (led !== 16'hABCD) begin bad++; $display("FAIL sw_store_led got=%h exp=abcd", led); end
  endtask

  task automatic test_button_press;
    btn_in = 4'b0010;
    tick(5);
    peek(4);
    total++; if (bus.rd_data !== 32'd0) begin bad++; $display("FAIL level_early got=%h exp=0", bus.rd_data); end
    tick(1);
    peek(4);
    total++; if (bus.rd_data !== 32'd2) begin bad++; $display("FAIL level_rise got=%h exp=2", bus.rd_data); end
    peek(5);
    total++; if (bus.rd_data !== 32'd2) begin bad++; $display("FAIL pend_b1 got=%h exp=2", bus.rd_data); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_lag got=%b exp=0", irq); end
    tick(1);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_set got=%b exp=1", irq); end
    peek(0); bus.rd_en = 1'b1; #1;
    total++; if (bus.rd_data !== 32'd2) begin bad++; $display("FAIL event_b1 got=%h exp=2", bus.rd_data); end
    tick(1);
    bus.rd_en = 1'b0;
    peek(5);
    total++; if (bus.rd_data !== 32'd0) begin bad++; $display("FAIL pend_clr got=%h exp=0", bus.rd_data); end
    tick(1);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clr got=%b exp=0", irq); end
    btn_in = 4'b0000;
    tick(8);
    peek(4);
    total++; if (bus.rd_data !== 32'd0) begin bad++; $display("FAIL level_release got=%h exp=0", bus.rd_data); end
    peek(5);
    total++; if (bus.rd_data !== 32'd0) begin bad++; $display("FAIL pend_release got=%h exp=0", bus.rd_data); end
  endtask

  task automatic test_glitch;
    btn_in = 4'b0001;
    tick(3);
    btn_in = 4'b0000;
    tick(8);
    peek(4);
    total++; if (bus.rd_data !== 32'd0) begin bad++; $display("FAIL glitch_level got=%h exp=0", bus.rd_data); end
    peek(5);
    total++; if (bus.rd_data !== 32'd0) begin bad++; $display("FAIL glitch_pend got=%h exp=0", bus.rd_data); end
  endtask

  task automatic test_two_buttons;
    btn_in = 4'b0101;
    tick(6);
    peek(5);
    total++; if (bus.rd_data !== 32'd5) begin bad++; $display("FAIL two_pend got=%h exp=5", bus.rd_data); end
    peek(0); bus.rd_en = 1'b1; #1;
    total++; if (bus.rd_data !== 32'd1) begin bad++; $display("FAIL two_ev1 got=%h exp=1", bus.rd_data); end
    tick(1);
    peek(5);
    total++; if (bus.rd_data !== 32'd4) begin bad++; $display("FAIL two_pend2 got=%h exp=4", bus.rd_data); end
    peek(0);
    total++; if (bus.rd_data !== 32'd3) begin bad++; $display("FAIL two_ev2 got=%h exp=3", bus.rd_data); end
    tick(1);
    peek(0);
    total++; if (bus.rd_data !== 32'd0) begin bad++; $display("FAIL two_ev3 got=%h exp=0", bus.rd_data); end
    tick(1);
    bus.rd_en = 1'b0;
    peek(5);
    total++; if (bus.rd_data !== 32'd0) begin bad++; $display("FAIL two_pend3 got=%h exp=0", bus.rd_data); end
    btn_in = 4'b0000;
    tick(8);
  endtask

  task automatic test_clear_collision;
    btn_in = 4'b0001;
    tick(6);
    btn_in = 4'b0000;
    tick(8);
    peek(4);
    total++; if (bus.rd_data !== 32'd0) begin bad++; $display("FAIL coll_lvl0 got=%h exp=0", bus.rd_data); end
    btn_in = 4'b0001;
    tick(5);
    peek(0); bus.rd_en = 1'b1; #1;
    total++; if (bus.rd_data !== 32'd1) begin bad++; $display("FAIL coll_ev got=%h exp=1", bus.rd_data); end
    tick(1);
    bus.rd_en = 1'b0;
    peek(5);
    total++; if (bus.rd_data !== 32'd1) begin bad++; $display("FAIL coll_set_wins got=%h exp=1", bus.rd_data); end
    peek(4);
    total++; if (bus.rd_data !== 32'd1) begin bad++; $display("FAIL coll_level got=%h exp=1", bus.rd_data); end
  endtask

  task automatic test_reset_mid_count;
    btn_in = 4'b0100;
    tick(4);
    reset = 1'b0; #1;
    peek(4);
    total++; if (bus.rd_data !== 32'd0) begin bad++; $display("FAIL rst_level got=%h exp=0", bus.rd_data); end
    peek(5);
    total++; if (bus.rd_data !== 32'd0) begin bad++; $display("FAIL rst_pend got=%h exp=0", bus.rd_data); end
    total++; if ({led, status, irq} !== 19'd0) begin bad++; $display("FAIL rst_outs got=%h exp=0", {led, status, irq}); end
    tick(2);
    reset = 1'b1;
    tick(5);
    peek(4);
    total++; if (bus.rd_data !== 32'd0) begin bad++; $display("FAIL rst_restart_early got=%h exp=0", bus.rd_data); end
    tick(1);
    peek(4);
    total++; if (bus.rd_data !== 32'd4) begin bad++; $display("FAIL rst_restart got=%h exp=4", bus.rd_data); end
    peek(5);
    total++; if (bus.rd_data !== 32'd4) begin bad++; $display("FAIL rst_restart_pend got=%h exp=4", bus.rd_data); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset;
    test_regs;
    test_sw;
    test_button_press;
    test_glitch;
    test_two_buttons;
    test_clear_collision;
    test_reset_mid_count;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mmio_io_ctrl.md
Name: mmio_io_ctrl

Overview:
- Parametrised memory-mapped I/O controller between the processor data port and the board I/O: N push-buttons, switch bank, LED register, game-status register.
- Replaces the ad-hoc address-decode, button-code mux and LED/status latch in the top level.
- Adds synchronisation, debounce, sticky edge capture with read-to-clear, and a multi-register map.
- The top level muxes rd_data onto q_dmem whenever hit=1.

Parameters:
- BASE_ADDR, 4096, word address of register 0.
- NUM_BTN, 4, number of push-buttons (1..15).
- SW_W, 16, switch bank width.
- LED_W, 16, LED register width.
- STAT_W, 2, status register width (01 = win, 10 = loss).
- DB_CYCLES, 250000, consecutive stable clocks required to accept a button change (10 ms at 25 MHz).

Ports:
- clock  in  1  system clock (25 MHz domain)
- reset  in  1  asynchronous, active-low reset
- addr  in  32  processor data address
- wr_en  in  1  processor store strobe
- rd_en  in  1  processor load strobe (high during a load's memory stage)
- wr_data  in  32  store data
- rd_data  out  32  read data, combinational from addr; 0 when hit=0
- hit  out  1  addr within BASE_ADDR..BASE_ADDR+5
- btn_in  in  NUM_BTN  raw asynchronous buttons
- sw_in  in  SW_W  raw asynchronous switches
- led  out  LED_W  LED register
- status  out  STAT_W  status register (to VGA)
- irq  out  1  OR of pending bits, registered

Behaviour:
- Reset (reset=0, asynchronous):
  - Clears led, status, pending, irq, all synchroniser flops, debounced levels and counters.
  - Reset mid-debounce discards the partial count.
  - Reset in the same cycle as a store means the store is lost.
- Register map (offset from BASE_ADDR):
  - 0 EVENT (RO, read-to-clear): returns i+1 for the lowest-index pending button i; returns 0 when none is pending.
  - 1 LED (RW): low LED_W bits.
  - 2 SW (RO): synchronised switches.
  - 3 STATUS (RW): low STAT_W bits.
  - 4 LEVEL (RO): debounced button levels.
  - 5 PENDING (RO): pending mask.
  - Unused upper read bits are 0. Stores to RO offsets are ignored.
- Read latency: rd_data is combinational in the same cycle as addr; reads have no side effects except EVENT.
- Writes: at the posedge where wr_en=1 and the offset matches, LED/STATUS take wr_data. The new value is visible on led/status and read back the following cycle.
- Synchronisation: btn_in and sw_in each pass through 2 flops. Switches are not debounced (2-cycle latency to SW).
- Debounce, per button:
  - The counter resets whenever the synced level equals the debounced level; otherwise it increments.
  - When the count reaches DB_CYCLES-1 while still differing, the debounced level toggles and the counter clears.
  - Latency from a stable raw change to the level change = 2 + DB_CYCLES clocks.
- Edge capture: a debounced 0->1 transition sets pending[i]. Releases do not set or clear pending. A second press while pending is still 1 is absorbed (no count).
- Read-to-clear:
  - At the posedge where rd_en=1 and offset=0, clear only the bit whose code was returned.
  - If that same bit gets a new rising edge in the same cycle, set wins and the bit stays 1.
  - Other bits are unaffected.
  - A read with no pending bits returns 0 and changes nothing.
- irq: registered version of the OR of pending; lags by 1 clock.
- Simultaneous store and load to different offsets cannot occur (single data port); if both strobes are high, the store and the clear both take effect.
- Arithmetic:
  - The code field is $clog2(NUM_BTN+1) bits, zero-extended to 32.
  - Counter width is $clog2(DB_CYCLES). DB_CYCLES=1 means accept after 1 stable cycle.

Decomposition:
- Shared package mmio_pkg: offset constants (OFF_EVENT=0, OFF_LED=1, OFF_SW=2, OFF_STATUS=3, OFF_LEVEL=4, OFF_PENDING=5), STATUS_WIN=2'b01, STATUS_LOSS=2'b10.
- One sub-module btn_debounce (parameter DB_CYCLES): 2-flop sync, counter, level output and rise pulse. Instantiated NUM_BTN times via generate.
- Decode, registers and the priority encoder stay in mmio_io_ctrl.

Test Plan (DB_CYCLES=4 in the bench):
- Reset then idle -> led=0, status=0, irq=0; reads at offsets 0..5 all return 0; hit=0 at addr 4095 and 4102.
- Store 0x0000ABCD to 4097, store 2 to 4099 -> led=0xABCD and status=2'b10 next cycle; reads return the same. Store to 4098 -> SW read unchanged.
- btn_in[1] held high for 6 clocks -> LEVEL bit1 rises exactly 6 clocks after the edge, PENDING=0x2, irq 1 clock later. Load at 4096 -> returns 2, PENDING=0 next cycle.
- Glitch btn_in[0] high for 3 clocks -> no level change, PENDING stays 0.
- Buttons 2 and 0 pressed -> PENDING=0x5. First EVENT read returns 1 and leaves PENDING=0x4. Second read returns 3. Third read returns 0.
- Button 0 rising pulse lands on the same cycle as an EVENT clear of bit0 -> PENDING bit0 remains 1. Assert reset mid-count -> level and pending 0, counters restart.
